// File: rtl/pong_frame_renderer.sv
// Pixel stage after the VGA sync generator: rebuilds (x,y) from blank/sync,
// draws paddles, ball and centre net, and registers RGB plus delayed sync.
module pong_frame_renderer #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned PADDLE_W   = 8,
    parameter int unsigned PADDLE_H   = 64,
    parameter int unsigned BALL_SIZE  = 8,
    parameter int unsigned PADDLE_L_X = 16,
    parameter int unsigned PADDLE_R_X = 616,
    parameter logic [23:0] FG_RGB     = 24'hFFFFFF,
    parameter logic [23:0] BG_RGB     = 24'h000000
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic       blank_n_in,
    input  logic       hs_in,
    input  logic       vs_in,
    input  logic [8:0] paddle_l_y,
    input  logic [8:0] paddle_r_y,
    input  logic [9:0] ball_x,
    input  logic [8:0] ball_y,
    output logic       frame_tick,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       blank_n_out,
    output logic       hs_out,
    output logic       vs_out
);

    localparam logic [8:0]  PADDLE_Y_RST = 9'(V_ACTIVE / 2 - PADDLE_H / 2);
    localparam logic [9:0]  BALL_X_RST   = 10'(H_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [8:0]  BALL_Y_RST   = 9'(V_ACTIVE / 2 - BALL_SIZE / 2);
    localparam logic [10:0] NET_X_LO     = 11'(H_ACTIVE / 2 - 2);
    localparam logic [10:0] NET_X_HI     = 11'(H_ACTIVE / 2 + 1);
    localparam logic [10:0] PL_X_LO      = 11'(PADDLE_L_X);
    localparam logic [10:0] PL_X_HI      = 11'(PADDLE_L_X + PADDLE_W - 1);
    localparam logic [10:0] PR_X_LO      = 11'(PADDLE_R_X);
    localparam logic [10:0] PR_X_HI      = 11'(PADDLE_R_X + PADDLE_W - 1);
    localparam logic [10:0] PADDLE_SPAN  = 11'(PADDLE_H - 1);
    localparam logic [10:0] BALL_SPAN    = 11'(BALL_SIZE - 1);
    localparam logic [10:0] X_LIMIT      = 11'(H_ACTIVE);
    localparam logic [10:0] Y_LIMIT      = 11'(V_ACTIVE);

    logic        blank_d_q, vs_d_q;
    logic [9:0]  x_q, x_d;
    logic [8:0]  y_q, y_d;
    logic        synced_q;
    logic [8:0]  pl_q, pr_q, by_q;
    logic [9:0]  bx_q;
    logic        tick_q;
    logic [23:0] rgb_q, rgb_d;
    logic        blank_q, hs_q, vs_q;

    logic        line_end, frame_start;
    logic [10:0] xe, ye;
    logic        in_active, hit_ball, hit_pl, hit_pr, hit_net;

    always_comb begin
        line_end    = blank_d_q & ~blank_n_in;
        frame_start = vs_d_q & ~vs_in;

        x_d = x_q;
        y_d = y_q;
        if (!vs_in || line_end) begin
            x_d = '0;
        end else if (blank_n_in && x_q != '1) begin
            x_d = x_q + 10'd1;
        end
        if (!vs_in) begin
            y_d = '0;
        end else if (line_end && y_q != '1) begin
            y_d = y_q + 9'd1;
        end
    end

    // Widened to 11 bits so objects near the bottom/right edge clip instead of wrapping.
    always_comb begin
        xe = {1'b0, x_q};
        ye = {2'b00, y_q};

        in_active = (xe < X_LIMIT) && (ye < Y_LIMIT);
        hit_ball  = (xe >= {1'b0, bx_q}) && (xe <= {1'b0, bx_q} + BALL_SPAN) &&
                    (ye >= {2'b00, by_q}) && (ye <= {2'b00, by_q} + BALL_SPAN);
        hit_pl    = (xe >= PL_X_LO) && (xe <= PL_X_HI) &&
                    (ye >= {2'b00, pl_q}) && (ye <= {2'b00, pl_q} + PADDLE_SPAN);
        hit_pr    = (xe >= PR_X_LO) && (xe <= PR_X_HI) &&
                    (ye >= {2'b00, pr_q}) && (ye <= {2'b00, pr_q} + PADDLE_SPAN);
        hit_net   = (xe >= NET_X_LO) && (xe <= NET_X_HI) && !y_q[4];

        // Every object shares one colour, so the ball/paddle/net priority collapses to an OR.
        rgb_d = '0;
        if (blank_n_in && synced_q) begin
            if (in_active && (hit_ball || hit_pl || hit_pr || hit_net)) begin
                rgb_d = FG_RGB;
            end else begin
                rgb_d = BG_RGB;
            end
        end
    end

    always_ff @(posedge clk_vga or posedge rst) begin
        if (rst) begin
            blank_d_q <= 1'b0;
            vs_d_q    <= 1'b1;
            x_q       <= '0;
            y_q       <= '0;
            synced_q  <= 1'b0;
            pl_q      <= PADDLE_Y_RST;
            pr_q      <= PADDLE_Y_RST;
            bx_q      <= BALL_X_RST;
            by_q      <= BALL_Y_RST;
            tick_q    <= 1'b0;
            rgb_q     <= '0;
            blank_q   <= 1'b0;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
        end else begin
            blank_d_q <= blank_n_in;
            vs_d_q    <= vs_in;
            x_q       <= x_d;
            y_q       <= y_d;
            tick_q    <= frame_start;
            rgb_q     <= rgb_d;
            blank_q   <= blank_n_in;
            hs_q      <= hs_in;
            vs_q      <= vs_in;
            if (frame_start) begin
                synced_q <= 1'b1;
                pl_q     <= paddle_l_y;
                pr_q     <= paddle_r_y;
                bx_q     <= ball_x;
                by_q     <= ball_y;
            end
        end
    end

    assign frame_tick  = tick_q;
    assign vga_r       = rgb_q[23:16];
    assign vga_g       = rgb_q[15:8];
    assign vga_b       = rgb_q[7:0];
    assign blank_n_out = blank_q;
    assign hs_out      = hs_q;
    assign vs_out      = vs_q;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: drives a compressed sync stream
// (full-width lines only where pixels are inspected) and checks captured frames.
module tb_pong_frame_renderer;

    logic       clk_vga = 1'b0;
    logic       rst = 1'b0;
    logic       blank_n_in = 1'b0;
    logic       hs_in = 1'b1;
    logic       vs_in = 1'b1;
    logic [8:0] paddle_l_y = '0;
    logic [8:0] paddle_r_y = '0;
    logic [9:0] ball_x = '0;
    logic [8:0] ball_y = '0;
    logic       frame_tick;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       blank_n_out, hs_out, vs_out;

    localparam logic [23:0] W = 24'hFFFFFF;
    localparam logic [23:0] K = 24'h000000;

    int checks = 0, errors = 0;
    int align_bad = 0, nz_cnt = 0, tick_cnt = 0, cyc = 0, tick_cyc = 0, tick_prev = 0;
    int chg_row = -1;
    logic [9:0]  chg_bx = '0;
    logic [23:0] last_rgb;
    logic        t1, t2;
    logic [23:0] fb [480][640];
    bit          full_row [480];

    always #5 clk_vga = ~clk_vga;

    pong_frame_renderer dut (
        .clk_vga(clk_vga), .rst(rst), .blank_n_in(blank_n_in), .hs_in(hs_in), .vs_in(vs_in),
        .paddle_l_y(paddle_l_y), .paddle_r_y(paddle_r_y), .ball_x(ball_x), .ball_y(ball_y),
        .frame_tick(frame_tick), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .blank_n_out(blank_n_out), .hs_out(hs_out), .vs_out(vs_out)
    );

    // One pixel clock: drive, let the edge capture, sample 1 ns later.
    task automatic step(input logic b, input logic h, input logic v);
        blank_n_in = b; hs_in = h; vs_in = v;
        @(posedge clk_vga); #1;
        cyc++;
        last_rgb = {vga_r, vga_g, vga_b};
        if (last_rgb !== '0) nz_cnt++;
        if (frame_tick === 1'b1) begin tick_cnt++; tick_prev = tick_cyc; tick_cyc = cyc; end
        if (!rst && (blank_n_out !== b || hs_out !== h || vs_out !== v)) align_bad++;
    endtask

    task automatic hblank();
        step(0, 1, 1); step(0, 1, 1); step(0, 0, 1); step(0, 0, 1); step(0, 1, 1); step(0, 1, 1);
    endtask

    task automatic vblank();
        for (int i = 0; i < 10; i++) step(0, 1, 1);
    endtask

    task automatic vsync_pulse();
        step(0, 1, 1); step(0, 1, 1);
        step(0, 1, 0); t1 = frame_tick;
        step(0, 1, 0); t2 = frame_tick;
        step(0, 1, 1); step(0, 1, 1); step(0, 1, 1);
    endtask

    task automatic vis_line(input int r);
        int w;
        w = full_row[r] ? 640 : 2;
        for (int i = 0; i < 640; i++) fb[r][i] = 'x;
        for (int i = 0; i < w; i++) begin step(1, 1, 1); fb[r][i] = last_rgb; end
        hblank();
    endtask

    task automatic run_rows(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            if (r == chg_row) ball_x = chg_bx;
            vis_line(r);
        end
    endtask

    task automatic run_frame();
        vsync_pulse();
        run_rows(0, 479);
        vblank();
    endtask

    task automatic clear_rows();
        for (int r = 0; r < 480; r++) full_row[r] = 1'b0;
    endtask

    task automatic test_reset();
        blank_n_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        #2 rst = 1'b1;
        @(posedge clk_vga); @(posedge clk_vga); #1;
        checks++; if ({vga_r, vga_g, vga_b} !== K) begin errors++; $display("FAIL reset_rgb got %h exp %h", {vga_r, vga_g, vga_b}, K); end
        checks++; if (blank_n_out !== 1'b0) begin errors++; $display("FAIL reset_blank got %b exp 0", blank_n_out); end
        checks++; if (hs_out !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", hs_out); end
        checks++; if (vs_out !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", vs_out); end
        checks++; if (frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick got %b exp 0", frame_tick); end
        blank_n_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        @(posedge clk_vga); #1 rst = 1'b0;
    endtask

    task automatic test_unsynced();
        clear_rows();
        full_row[0] = 1'b1; full_row[1] = 1'b1; full_row[2] = 1'b1;
        nz_cnt = 0; tick_cnt = 0;
        run_rows(0, 2);
        vblank();
        checks++; if (nz_cnt !== 0) begin errors++; $display("FAIL unsynced_rgb nonzero_pixels got %0d exp 0", nz_cnt); end
        checks++; if (tick_cnt !== 0) begin errors++; $display("FAIL unsynced_tick got %0d exp 0", tick_cnt); end
    endtask

    task automatic test_frame_tick();
        int exp_period;
        paddle_l_y = 9'd100; paddle_r_y = 9'd200; ball_x = 10'd320; ball_y = 9'd240;
        clear_rows();
        full_row[0] = 1'b1; full_row[5] = 1'b1; full_row[15] = 1'b1; full_row[16] = 1'b1;
        full_row[99] = 1'b1; full_row[130] = 1'b1; full_row[240] = 1'b1; full_row[247] = 1'b1;
        full_row[248] = 1'b1; full_row[263] = 1'b1; full_row[264] = 1'b1;
        exp_period = 17;
        for (int r = 0; r < 480; r++) exp_period += (full_row[r] ? 640 : 2) + 6;
        tick_cnt = 0;
        run_frame();
        checks++; if (t1 !== 1'b1) begin errors++; $display("FAIL tick_first_vs_low got %b exp 1", t1); end
        checks++; if (t2 !== 1'b0) begin errors++; $display("FAIL tick_one_cycle got %b exp 0", t2); end
        run_frame();
        checks++; if (tick_cnt !== 2) begin errors++; $display("FAIL tick_count got %0d exp 2", tick_cnt); end
        checks++; if (tick_cyc - tick_prev !== exp_period) begin errors++; $display("FAIL tick_period got %0d exp %0d", tick_cyc - tick_prev, exp_period); end
    endtask

    task automatic test_objects();
        int rr [24] = '{130, 99, 130, 130, 130, 130, 263, 264, 240, 240, 240, 240,
                        240, 247, 240, 248, 240, 0, 15, 16, 5, 5, 5, 5};
        int cc [24] = '{20, 20, 15, 16, 23, 24, 620, 620, 615, 616, 623, 624,
                        320, 327, 328, 320, 319, 319, 319, 319, 317, 318, 321, 322};
        logic [23:0] ee [24] = '{W, K, K, W, W, K, W, K, K, W, W, K,
                                 W, W, K, K, K, W, W, K, K, W, W, K};
        for (int k = 0; k < 24; k++) begin
            checks++;
            if (fb[rr[k]][cc[k]] !== ee[k]) begin
                errors++;
                $display("FAIL objects pixel(%0d,%0d) got %h exp %h", cc[k], rr[k], fb[rr[k]][cc[k]], ee[k]);
            end
        end
    endtask

    task automatic test_ball_on_net();
        int rr [9] = '{0, 0, 0, 0, 0, 7, 8, 8, 8};
        int cc [9] = '{316, 323, 324, 315, 319, 323, 319, 316, 322};
        logic [23:0] ee [9] = '{W, W, K, K, W, W, W, K, K};
        paddle_l_y = 9'd100; paddle_r_y = 9'd200; ball_x = 10'd316; ball_y = 9'd0;
        clear_rows();
        full_row[0] = 1'b1; full_row[7] = 1'b1; full_row[8] = 1'b1;
        run_frame();
        for (int k = 0; k < 9; k++) begin
            checks++;
            if (fb[rr[k]][cc[k]] !== ee[k]) begin
                errors++;
                $display("FAIL ball_on_net pixel(%0d,%0d) got %h exp %h", cc[k], rr[k], fb[rr[k]][cc[k]], ee[k]);
            end
        end
    endtask

    task automatic test_midframe_update();
        paddle_l_y = 9'd0; paddle_r_y = 9'd0; ball_x = 10'd316; ball_y = 9'd200;
        clear_rows();
        full_row[200] = 1'b1;
        chg_row = 100; chg_bx = 10'd400;
        run_frame();
        chg_row = -1;
        checks++; if (fb[200][316] !== W) begin errors++; $display("FAIL midframe_old_pos got %h exp %h", fb[200][316], W); end
        checks++; if (fb[200][400] !== K) begin errors++; $display("FAIL midframe_new_pos_early got %h exp %h", fb[200][400], K); end
        run_frame();
        checks++; if (fb[200][400] !== W) begin errors++; $display("FAIL nextframe_new_pos got %h exp %h", fb[200][400], W); end
        checks++; if (fb[200][407] !== W) begin errors++; $display("FAIL nextframe_new_right got %h exp %h", fb[200][407], W); end
        checks++; if (fb[200][316] !== K) begin errors++; $display("FAIL nextframe_old_gone got %h exp %h", fb[200][316], K); end
    endtask

    task automatic test_paddle_clip();
        int rr [8] = '{0, 33, 449, 450, 479, 479, 479, 0};
        int cc [8] = '{20, 20, 20, 20, 16, 23, 24, 620};
        logic [23:0] ee [8] = '{K, K, K, W, W, W, K, W};
        paddle_l_y = 9'd450; paddle_r_y = 9'd0; ball_x = 10'd500; ball_y = 9'd100;
        clear_rows();
        full_row[0] = 1'b1; full_row[33] = 1'b1; full_row[449] = 1'b1;
        full_row[450] = 1'b1; full_row[479] = 1'b1;
        run_frame();
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (fb[rr[k]][cc[k]] !== ee[k]) begin
                errors++;
                $display("FAIL paddle_clip pixel(%0d,%0d) got %h exp %h", cc[k], rr[k], fb[rr[k]][cc[k]], ee[k]);
            end
        end
    endtask

    task automatic test_reset_midframe();
        paddle_l_y = 9'd180; paddle_r_y = 9'd0; ball_x = 10'd500; ball_y = 9'd100;
        clear_rows();
        full_row[200] = 1'b1; full_row[205] = 1'b1; full_row[210] = 1'b1;
        vsync_pulse();
        run_rows(0, 199);
        for (int i = 0; i <= 20; i++) step(1, 1, 1);
        checks++; if (last_rgb !== W) begin errors++; $display("FAIL pre_reset_pixel got %h exp %h", last_rgb, W); end
        rst = 1'b1;
        #1;
        checks++; if ({vga_r, vga_g, vga_b} !== K) begin errors++; $display("FAIL async_reset_rgb got %h exp %h", {vga_r, vga_g, vga_b}, K); end
        checks++; if (blank_n_out !== 1'b0) begin errors++; $display("FAIL async_reset_blank got %b exp 0", blank_n_out); end
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            checks++;
            if (blank_n_out !== 1'b0 || hs_out !== 1'b1 || vs_out !== 1'b1 || {vga_r, vga_g, vga_b} !== K) begin
                errors++;
                $display("FAIL reset_hold cycle %0d got blank=%b hs=%b vs=%b rgb=%h exp 0 1 1 000000",
                         i, blank_n_out, hs_out, vs_out, {vga_r, vga_g, vga_b});
            end
        end
        #1 rst = 1'b0;
        nz_cnt = 0;
        for (int i = 24; i < 640; i++) step(1, 1, 1);
        hblank();
        run_rows(201, 479);
        vblank();
        checks++; if (nz_cnt !== 0) begin errors++; $display("FAIL post_reset_rgb nonzero_pixels got %0d exp 0", nz_cnt); end
        run_frame();
        checks++; if (fb[200][20] !== W) begin errors++; $display("FAIL resync_paddle got %h exp %h", fb[200][20], W); end
        checks++; if (fb[200][15] !== K) begin errors++; $display("FAIL resync_bg got %h exp %h", fb[200][15], K); end
    endtask

    task automatic test_alignment();
        checks++; if (align_bad !== 0) begin errors++; $display("FAIL sync_alignment misaligned_cycles got %0d exp 0", align_bad); end
    endtask

    initial begin
        test_reset();
        test_unsynced();
        test_frame_tick();
        test_objects();
        test_ball_on_net();
        test_midframe_update();
        test_paddle_clip();
        test_reset_midframe();
        test_alignment();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20_000_000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/pong_frame_renderer.md
# pong_frame_renderer

Pixel-generation stage sitting directly downstream of the VGA sync generator. Reconstructs the active-area pixel coordinate from the incoming blank/sync stream, then draws the two paddles, the ball and the centre net as 24-bit RGB. Game-object positions are latched once per frame so game logic can update them at any time without tearing. Outputs RGB plus delayed sync/blank, aligned for the video DAC.

## Interface
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in lines
- BALL_SIZE, 8, ball edge length in pixels/lines
- PADDLE_L_X, 16, left paddle leftmost column
- PADDLE_R_X, 616, right paddle leftmost column
- FG_RGB, 24'hFFFFFF, colour of paddles/ball/net
- BG_RGB, 24'h000000, background colour

- clk_vga  in  1  pixel clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- blank_n_in  in  1  high during visible pixels (from sync generator)
- hs_in  in  1  horizontal sync, active low
- vs_in  in  1  vertical sync, active low
- paddle_l_y  in  9  left paddle top line
- paddle_r_y  in  9  right paddle top line
- ball_x  in  10  ball leftmost column
- ball_y  in  9  ball top line
- frame_tick  out  1  one-cycle pulse at start of each frame's vsync
- vga_r, vga_g, vga_b  out  8 each  pixel colour
- blank_n_out  out  1  blank_n_in delayed 1 cycle
- hs_out, vs_out  out  1 each  hs_in/vs_in delayed 1 cycle

## Operation
- Edge detect: registered copies blank_d, vs_d. Line end = blank_d & ~blank_n_in. Frame start = vs_d & ~vs_in.
- x counter (10 bit): +1 each cycle blank_n_in=1, saturating at 1023; cleared to 0 at line end and while vs_in=0.
- y counter (9 bit): +1 at line end, saturating at 511; cleared to 0 while vs_in=0.
- Pixel coordinate of the current visible cycle = (x, y) before increment; first visible pixel of a frame is (0,0).
- Frame start: frame_tick=1 for that one cycle; shadow registers capture paddle_l_y, paddle_r_y, ball_x, ball_y; synced flag set.
- synced: cleared by reset, set at first frame start, never cleared otherwise. While synced=0, RGB forced to 0.
- Hit tests use shadow values, 11-bit arithmetic (no wrap): paddle hit when x in [PX, PX+PADDLE_W-1] and y in [py, py+PADDLE_H-1]; ball hit when x in [bx, bx+BALL_SIZE-1] and y in [by, by+BALL_SIZE-1]; net when x in [318,321] and y[4]=0. Objects extending past the active area are clipped naturally.
- Priority: ball > left paddle > right paddle > net > BG_RGB. Hit selects FG_RGB.
- If blank_n_in=0 the output RGB is 0 regardless of hits.

## Timing
- Latency 1 cycle: RGB for the pixel sampled at edge n appears at edge n+1, together with blank_n_out/hs_out/vs_out from edge n.
- frame_tick is combinational from edge-detect registers? No: registered, asserted the cycle after vs_in is first sampled low, same cycle shadows update; positions changed on that cycle's inputs are captured.
- Reset values: vga_r/g/b=0, blank_n_out=0, hs_out=1, vs_out=1, frame_tick=0, x=y=0, blank_d=0, vs_d=1, synced=0; shadows paddle_l_y=paddle_r_y=208, ball_x=316, ball_y=236.
- Reset mid-frame: outputs go to reset values asynchronously; after release RGB stays 0 until next vsync falling edge, sync/blank pass through with 1-cycle delay.
- Line end and vs_in low in same cycle: clear wins (y=0).
- Input changes to positions mid-frame have no visible effect until next frame start.

## Test plan
- Reset then 640x480@800x525 sync stream: RGB=0 for entire first partial frame; frame_tick pulses once per 420000 cycles after first vsync.
- Paddles at 100/200, ball (320,240): pixel (20,130) -> FFFFFF; (20,99) -> 000000; (620,263) -> FFFFFF; (620,264) -> 000000; ball covers (320..327,240..247).
- Net: (319,0) and (319,15) white, (319,16) black, (317,5) black; ball at (316,0) overlapping net -> white, no glitches.
- Change ball_x from 316 to 400 mid-frame at line 100: remaining lines still draw ball at 316; next frame at 400.
- paddle_l_y=450: paddle drawn lines 450..479 only, no wrap to top lines 0..33.
- Assert rst during line 200 for 3 cycles: all outputs at reset values within same cycle; RGB=0 until next frame_tick; alignment of blank_n_out to blank_n_in exactly 1 cycle throughout.
